// File: rtl/spi_disp_slave.sv
// SPI mode-0 slave that oversamples ss/sclk/mosi on clk. It receives one DATA_W-bit word per frame
// and returns the reply word that was captured when ss fell.
module spi_disp_slave #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ss_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;
    localparam int         CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    // Pin bundle order is {ss, sclk, mosi}. The idle levels are 1, 0, 0.
    logic [2:0]             pin_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   ss_s, sclk_s, mosi_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pin_sync_q[i] <= 3'b100;
            end
            fill_q <= '0;
        end else begin
            pin_sync_q[0] <= {ss_i, sclk_i, mosi_i};
            fill_q[0]     <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pin_sync_q[i] <= pin_sync_q[i-1];
                fill_q[i]     <= fill_q[i-1];
            end
        end
    end

    assign ss_s   = pin_sync_q[SYNC_STAGES-1][2];
    assign sclk_s = pin_sync_q[SYNC_STAGES-1][1];
    assign mosi_s = pin_sync_q[SYNC_STAGES-1][0];

    logic ss_prev_q, sclk_prev_q;
    logic ss_fall_q, ss_rise_q, sclk_rise_q, sclk_fall_q;
    logic mosi_q, armed_q;

    // The edge flags are registered. mosi_q is delayed by the same amount so that it lines up with
    // sclk_rise_q. armed_q becomes set only after the chain holds real pin samples and ss is seen
    // high. Because of this, an ss that is already low at reset release cannot start a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            ss_fall_q   <= 1'b0;
            ss_rise_q   <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            mosi_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            ss_prev_q   <= ss_s;
            sclk_prev_q <= sclk_s;
            ss_fall_q   <= ss_prev_q & ~ss_s;
            ss_rise_q   <= ~ss_prev_q & ss_s;
            sclk_rise_q <= ~sclk_prev_q & sclk_s;
            sclk_fall_q <= sclk_prev_q & ~sclk_s;
            mosi_q      <= mosi_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & ss_s);
        end
    end

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall_q && armed_q) begin
                    state_d = ST_ACTIVE;
                    tx_sh_d = tx_data_i;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ACTIVE: begin
                // A frame end that arrives together with an sclk edge takes priority and swallows that edge.
                if (ss_rise_q) begin
                    state_d = ST_IDLE;
                    if (cnt_q == CNT_FULL && !ovf_q) begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (sclk_rise_q) begin
                        if (cnt_q == CNT_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_q};
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                    if (sclk_fall_q) begin
                        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso_o      = (state_q == ST_ACTIVE) ? tx_sh_q[DATA_W-1] : 1'b1;
    assign busy_o      = (state_q == ST_ACTIVE);
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_disp_slave.sv
// Testbench for spi_disp_slave. It acts as an SPI master at clk/8 and compares the DUT against a
// frame-level model: a frame of exactly DATA_W bits updates rx_data, and any other frame gives frame_err.
module tb_spi_disp_slave;
    localparam int W    = 16;
    localparam int S    = 2;
    localparam int HALF = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ss, sclk, mosi;
    logic         miso;
    logic [W-1:0] tx_data;
    logic [W-1:0] rx_data;
    logic         rx_valid, frame_err, busy;

    int n_cmp = 0;
    int n_mis = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    logic [W-1:0] model_rx;

    always #5 clk = ~clk;

    spi_disp_slave #(.DATA_W(W), .SYNC_STAGES(S)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ss_i       (ss),
        .sclk_i     (sclk),
        .mosi_i     (mosi),
        .miso_o     (miso),
        .tx_data_i  (tx_data),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .frame_err_o(frame_err),
        .busy_o     (busy)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends the nbits lowest bits of 'bits' MSB first. While it does so it checks miso against the reply word.
    task automatic run_frame(input string name, input logic [W-1:0] tx, input logic [31:0] bits,
                             input int nbits);
        int   rv0, fe0, lat;
        bit   ok;
        logic exp_miso;
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        @(negedge clk);
        tx_data = tx;
        ss      = 1'b0;
        repeat (8) @(negedge clk);
        check_val({name, "_busy_in"}, {31'd0, busy}, 32'd1);
        tx_data = W'($urandom);
        for (int i = 0; i < nbits; i++) begin
            mosi = bits[nbits-1-i];
            repeat (HALF) @(negedge clk);
            exp_miso = (i < W) ? tx[W-1-i] : 1'b0;
            check_val($sformatf("%s_miso%0d", name, i), {31'd0, miso}, {31'd0, exp_miso});
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ss  = 1'b1;
        lat = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (lat == 0 && (rx_valid === 1'b1 || frame_err === 1'b1)) lat = k;
        end
        ok = (nbits == W);
        if (ok) model_rx = bits[W-1:0];
        check_val({name, "_latency"}, lat, S + 2);
        check_val({name, "_rx_valid_n"}, rv_cnt - rv0, ok ? 1 : 0);
        check_val({name, "_frame_err_n"}, fe_cnt - fe0, ok ? 0 : 1);
        check_val({name, "_rx_data"}, {16'd0, rx_data}, {16'd0, model_rx});
        check_val({name, "_busy_out"}, {31'd0, busy}, 32'd0);
        $display("frame %s: tx=%h bits=%0d data=%h rx_data=%h lat=%0d", name, tx, nbits, bits, rx_data, lat);
    endtask

    task automatic reset_mid_frame();
        int rv0, fe0;
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        @(negedge clk);
        tx_data = 16'h5A5A;
        ss      = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_rx = '0;
        check_val("rstmid_miso", {31'd0, miso}, 32'd1);
        check_val("rstmid_rx_data", {16'd0, rx_data}, {16'd0, model_rx});
        check_val("rstmid_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_val("rstmid_no_restart", {31'd0, busy}, 32'd0);
        ss = 1'b1;
        repeat (16) @(negedge clk);
        check_val("rstmid_rx_valid_n", rv_cnt - rv0, 0);
        check_val("rstmid_frame_err_n", fe_cnt - fe0, 0);
        $display("reset mid-frame: rx_data=%h busy=%0b", rx_data, busy);
    endtask

    task automatic idle_noise();
        int rv0, fe0, bad;
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || miso !== 1'b1) bad++;
            sclk = 1'($urandom);
            mosi = 1'($urandom);
        end
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        check_val("noise_bad_cycles", bad, 0);
        check_val("noise_rx_valid_n", rv_cnt - rv0, 0);
        check_val("noise_frame_err_n", fe_cnt - fe0, 0);
        $display("idle noise: bad_cycles=%0d", bad);
    endtask

    initial begin
        int          nb;
        logic [31:0] d;
        rst_n    = 1'b0;
        ss       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        tx_data  = '0;
        model_rx = '0;
        repeat (3) @(negedge clk);
        check_val("reset_miso", {31'd0, miso}, 32'd1);
        check_val("reset_rx_data", {16'd0, rx_data}, 32'd0);
        check_val("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_val("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_frame("normal", 16'hA55A, 32'h1234, W);
        run_frame("short", W'($urandom), $urandom & 32'h7FFF, W - 1);
        run_frame("long", W'($urandom), {15'd0, 16'hBEEF, 1'b1}, W + 1);
        run_frame("zero", W'($urandom), 32'd0, 0);
        run_frame("b2b_a", W'($urandom), 32'h0001, W);
        run_frame("b2b_b", W'($urandom), 32'hFFFF, W);
        reset_mid_frame();
        run_frame("after_rst", W'($urandom), 32'h00FF, W);
        idle_noise();

        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 5))
                0:       nb = W - 1;
                1:       nb = W + 1;
                2:       nb = 0;
                default: nb = W;
            endcase
            d = $urandom & ((32'd1 << nb) - 32'd1);
            run_frame($sformatf("rand%0d", t), W'($urandom), d, nb);
        end

        check_val("valid_and_err_same_cycle", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
